apb4_mem_slave: RTL and testbench

APB4_MEM_SLAVE -- requirements
Module: apb4_mem_slave

---
 rtl/apb_pkg.sv | 20 ++
 rtl/apb4_mem_slave_if.sv | 25 ++
 rtl/apb_strb_ram.sv | 36 +++
 rtl/apb4_mem_slave.sv | 173 +++++++++++++++++
 tb/tb_apb4_mem_slave.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared APB slave types: FSM state encoding and transfer error-decode reasons.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_UNALIGNED = 2'd1,
        ERR_RANGE     = 2'd2,
        ERR_READONLY  = 2'd3
    } err_t;

    // Wait-state counter width; covers WAIT_CYC up to 15.
    localparam int unsigned CNTW = 4;

endpackage

// File: rtl/apb4_mem_slave_if.sv
// APB4 bus bundle between a master and the memory slave.
interface apb4_mem_slave_if #(
    parameter int unsigned ADDRW = 8,
    parameter int unsigned DATAW = 32
);
    logic [ADDRW-1:0]   paddr;
    logic               psel;
    logic               penable;
    logic               pwrite;
    logic [DATAW-1:0]   pwdata;
    logic [DATAW/8-1:0] pstrb;
    logic [DATAW-1:0]   prdata;
    logic               pready;
    logic               pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_strb_ram.sv
// DEPTH x DATAW storage with per-byte write enables, asynchronous read, cleared on reset.
module apb_strb_ram #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned DATAW = 32,
    parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [AW-1:0]      addr,
    input  logic [DATAW/8-1:0] strb,
    input  logic [DATAW-1:0]   wdata,
    output logic [DATAW-1:0]   rdata_c
);
    localparam int unsigned STRBW = DATAW / 8;

    logic [DATAW-1:0] mem [DEPTH];

    // Byte-lane write; lanes with a clear strobe keep their old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < int'(STRBW); b++) begin
                if (strb[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata_c = mem[addr];

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 memory slave: setup capture, error decode, programmable wait states and
// byte-strobed writes into an apb_strb_ram.
module apb4_mem_slave
    import apb_pkg::*;
#(
    parameter int unsigned ADDRW    = 8,
    parameter int unsigned DATAW    = 32,
    parameter int unsigned DEPTH    = 64,
    parameter int unsigned WAIT_CYC = 0,
    parameter int unsigned RO_BASE  = DEPTH
) (
    input logic             clk,
    input logic             rst_n,
    apb4_mem_slave_if.slave apb
);
    localparam int unsigned STRBW = DATAW / 8;
    localparam int unsigned OFFW  = $clog2(STRBW);
    localparam int unsigned MEMAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRW-1:0] OFF_MASK = ADDRW'((64'd1 << OFFW) - 64'd1);

    state_t             state, state_nxt;
    logic [CNTW-1:0]    cnt, cnt_nxt;
    logic               pready_q, pready_nxt;
    logic               pslverr_q, pslverr_nxt;
    logic [DATAW-1:0]   prdata_q, prdata_nxt;

    logic [MEMAW-1:0]   cap_idx;
    logic               cap_write;
    logic [DATAW-1:0]   cap_wdata;
    logic [STRBW-1:0]   cap_strb;
    err_t               cap_err;

    logic               setup_c;
    logic               cap_load_c;
    logic               ram_we_c;
    logic [ADDRW-1:0]   word_idx_c;
    err_t               dec_err_c;
    logic [MEMAW-1:0]   ram_addr_c;
    logic [DATAW-1:0]   ram_rdata_c;

    assign setup_c    = apb.psel && !apb.penable;
    assign word_idx_c = apb.paddr >> OFFW;

    // Error decode on the live setup-phase address; the result is captured with it.
    always_comb begin
        dec_err_c = ERR_NONE;
        if ((apb.paddr & OFF_MASK) != '0) begin
            dec_err_c = ERR_UNALIGNED;
        end else if (32'(word_idx_c) >= DEPTH) begin
            dec_err_c = ERR_RANGE;
        end else if (apb.pwrite && (32'(word_idx_c) >= RO_BASE)) begin
            dec_err_c = ERR_READONLY;
        end
    end

    // In IDLE the setup address is being captured this edge, so read through it directly.
    assign ram_addr_c = (state == IDLE) ? MEMAW'(word_idx_c) : cap_idx;

    apb_strb_ram #(
        .DEPTH (DEPTH),
        .DATAW (DATAW),
        .AW    (MEMAW)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (ram_we_c),
        .addr    (ram_addr_c),
        .strb    (cap_strb),
        .wdata   (cap_wdata),
        .rdata_c (ram_rdata_c)
    );

    // State register plus registered outputs and captured transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            cap_idx   <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
            cap_strb  <= '0;
            cap_err   <= ERR_NONE;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pready_q  <= pready_nxt;
            pslverr_q <= pslverr_nxt;
            prdata_q  <= prdata_nxt;
            if (cap_load_c) begin
                cap_idx   <= MEMAW'(word_idx_c);
                cap_write <= apb.pwrite;
                cap_wdata <= apb.pwdata;
                cap_strb  <= apb.pstrb;
                cap_err   <= dec_err_c;
            end
        end
    end

    // Next-state logic; ACK always lasts a single cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (setup_c) begin
                    state_nxt = (WAIT_CYC == 0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!apb.psel) begin
                    state_nxt = IDLE;
                end else if (cnt == CNTW'(1)) begin
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output and datapath controls; outputs fall back to 0 unless entering ACK.
    always_comb begin
        cnt_nxt     = cnt;
        pready_nxt  = 1'b0;
        pslverr_nxt = 1'b0;
        prdata_nxt  = '0;
        cap_load_c  = 1'b0;
        ram_we_c    = 1'b0;
        case (state)
            IDLE: begin
                if (setup_c) begin
                    cap_load_c = 1'b1;
                    if (WAIT_CYC == 0) begin
                        pready_nxt  = 1'b1;
                        pslverr_nxt = (dec_err_c != ERR_NONE);
                        if (!apb.pwrite && (dec_err_c == ERR_NONE)) begin
                            prdata_nxt = ram_rdata_c;
                        end
                    end else begin
                        cnt_nxt = CNTW'(WAIT_CYC);
                    end
                end
            end
            WAIT: begin
                if (!apb.psel) begin
                    cnt_nxt = '0;
                end else if (cnt == CNTW'(1)) begin
                    cnt_nxt     = '0;
                    pready_nxt  = 1'b1;
                    pslverr_nxt = (cap_err != ERR_NONE);
                    if (!cap_write && (cap_err == ERR_NONE)) begin
                        prdata_nxt = ram_rdata_c;
                    end
                end else begin
                    cnt_nxt = cnt - CNTW'(1);
                end
            end
            ACK: begin
                ram_we_c = apb.psel && apb.penable && cap_write && (cap_err == ERR_NONE);
            end
            default: begin
                cnt_nxt = '0;
            end
        endcase
    end

    assign apb.prdata  = prdata_q;
    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;

endmodule

// File: tb/tb_apb4_mem_slave.sv
// Bench for apb4_mem_slave: a zero-wait and a three-wait instance share one driven bus,
// results are compared against an array-based memory model.
module tb_apb4_mem_slave;

    logic        clk;
    logic        rst_n;
    logic [9:0]  paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    int          tgt;

    int n_checks = 0;
    int n_fail   = 0;
    int idle_leak = 0;

    logic [31:0] mem_m [2][64];
    int          wc [2];

    apb4_mem_slave_if #(.ADDRW(10), .DATAW(32)) bus0 ();
    apb4_mem_slave_if #(.ADDRW(10), .DATAW(32)) bus3 ();

    apb4_mem_slave #(.ADDRW(10), .DATAW(32), .DEPTH(64), .WAIT_CYC(0), .RO_BASE(60))
        u_dut0 (.clk(clk), .rst_n(rst_n), .apb(bus0));
    apb4_mem_slave #(.ADDRW(10), .DATAW(32), .DEPTH(64), .WAIT_CYC(3), .RO_BASE(60))
        u_dut3 (.clk(clk), .rst_n(rst_n), .apb(bus3));

    assign bus0.paddr   = paddr;   assign bus3.paddr   = paddr;
    assign bus0.pwrite  = pwrite;  assign bus3.pwrite  = pwrite;
    assign bus0.pwdata  = pwdata;  assign bus3.pwdata  = pwdata;
    assign bus0.pstrb   = pstrb;   assign bus3.pstrb   = pstrb;
    assign bus0.penable = penable; assign bus3.penable = penable;
    assign bus0.psel    = psel && (tgt == 0);
    assign bus3.psel    = psel && (tgt == 1);

    logic [31:0] obs_prdata;
    logic        obs_pready, obs_pslverr;
    assign obs_prdata  = (tgt == 1) ? bus3.prdata  : bus0.prdata;
    assign obs_pready  = (tgt == 1) ? bus3.pready  : bus0.pready;
    assign obs_pslverr = (tgt == 1) ? bus3.pslverr : bus0.pslverr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // Reference model: error rules and byte-masked update straight from the address map.
    function automatic logic exp_err(input logic [9:0] a, input logic w);
        int ia = int'(a);
        return ((ia % 4) != 0) || ((ia / 4) >= 64) || (w && ((ia / 4) >= 60));
    endfunction

    task automatic model_xfer(input int t, input logic [9:0] a, input logic w,
                              input logic [31:0] d, input logic [3:0] s,
                              output logic [31:0] rd, output logic er);
        logic [31:0] mask;
        int idx = int'(a) / 4;
        er = exp_err(a, w);
        rd = 32'h0;
        if (!er && !w) rd = mem_m[t][idx];
        if (!er && w) begin
            mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
            mem_m[t][idx] = (mem_m[t][idx] & ~mask) | (d & mask);
        end
    endtask

    task automatic model_clear();
        for (int t = 0; t < 2; t++)
            for (int i = 0; i < 64; i++) mem_m[t][i] = 32'h0;
    endtask

    // Drives one full transfer starting at the current cycle; returns the access cycle of pready.
    task automatic xfer(input int t, input logic [9:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic er, output int lat);
        tgt = t; paddr = a; pwrite = w; pwdata = d; pstrb = s;
        psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        lat = 0; rd = 32'h0; er = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (obs_pready) begin
                lat = c; rd = obs_prdata; er = obs_pslverr;
                break;
            end else if (obs_prdata !== 32'h0) begin
                idle_leak++;
            end
        end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; tgt = 0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus0.pready !== 1'b0) begin n_fail++; $display("FAIL reset_pready0: got %b want 0", bus0.pready); end
        n_checks++; if (bus0.prdata !== 32'h0) begin n_fail++; $display("FAIL reset_prdata0: got %h want 0", bus0.prdata); end
        n_checks++; if (bus3.pready !== 1'b0) begin n_fail++; $display("FAIL reset_pready3: got %b want 0", bus3.pready); end
        n_checks++; if (bus3.pslverr !== 1'b0) begin n_fail++; $display("FAIL reset_pslverr3: got %b want 0", bus3.pslverr); end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd, erd; logic er, eer; int lat;
        model_xfer(0, 10'h004, 1'b1, 32'hDEADBEEF, 4'hF, erd, eer);
        xfer(0, 10'h004, 1'b1, 32'hDEADBEEF, 4'hF, rd, er, lat);
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL wr_latency: got %0d want 1", lat); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr_pslverr: got %b want 0", er); end
        model_xfer(0, 10'h004, 1'b0, 32'h0, 4'h0, erd, eer);
        xfer(0, 10'h004, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL rd_latency: got %0d want 1", lat); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h want deadbeef", rd); end
        n_checks++; if (er !== eer) begin n_fail++; $display("FAIL rd_pslverr: got %b want %b", er, eer); end
    endtask

    task automatic test_strobes();
        logic [31:0] rd, erd; logic er, eer; int lat;
        model_xfer(0, 10'h008, 1'b1, 32'h11223344, 4'hF, erd, eer);
        xfer(0, 10'h008, 1'b1, 32'h11223344, 4'hF, rd, er, lat);
        model_xfer(0, 10'h008, 1'b1, 32'hAABBCCDD, 4'h5, erd, eer);
        xfer(0, 10'h008, 1'b1, 32'hAABBCCDD, 4'h5, rd, er, lat);
        model_xfer(0, 10'h008, 1'b0, 32'h0, 4'h0, erd, eer);
        xfer(0, 10'h008, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL strb_merge: got %h want 11bb33dd", rd); end
        n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL strb_model: got %h want %h", rd, erd); end
        // Empty strobe: legal write that leaves storage untouched.
        model_xfer(0, 10'h008, 1'b1, 32'hFFFFFFFF, 4'h0, erd, eer);
        xfer(0, 10'h008, 1'b1, 32'hFFFFFFFF, 4'h0, rd, er, lat);
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL strb0_pslverr: got %b want 0", er); end
        xfer(0, 10'h008, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (rd !== 32'h11BB33DD) begin n_fail++; $display("FAIL strb0_data: got %h want 11bb33dd", rd); end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd, erd; logic er, eer; int lat;
        model_xfer(1, 10'h020, 1'b1, 32'hCAFE0123, 4'hF, erd, eer);
        xfer(1, 10'h020, 1'b1, 32'hCAFE0123, 4'hF, rd, er, lat);
        n_checks++; if (lat != 4) begin n_fail++; $display("FAIL wait_wr_latency: got %0d want 4", lat); end
        model_xfer(1, 10'h020, 1'b0, 32'h0, 4'h0, erd, eer);
        xfer(1, 10'h020, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (lat != 4) begin n_fail++; $display("FAIL wait_rd_latency: got %0d want 4", lat); end
        n_checks++; if (rd !== 32'hCAFE0123) begin n_fail++; $display("FAIL wait_rd_data: got %h want cafe0123", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd, erd; logic er, eer; int lat;
        model_xfer(0, 10'h000, 1'b1, 32'h5A5A5A5A, 4'hF, erd, eer);
        xfer(0, 10'h000, 1'b1, 32'h5A5A5A5A, 4'hF, rd, er, lat);
        xfer(0, 10'h100, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_range_pslverr: got %b want 1", er); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_range_prdata: got %h want 0", rd); end
        xfer(0, 10'h0F0, 1'b1, 32'h12345678, 4'hF, rd, er, lat);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_ro_pslverr: got %b want 1", er); end
        xfer(0, 10'h0F0, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if ({er, rd} !== 33'h0) begin n_fail++; $display("FAIL err_ro_unchanged: got %b/%h want 0/0", er, rd); end
        xfer(0, 10'h002, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL err_unal_pslverr: got %b want 1", er); end
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL err_unal_prdata: got %h want 0", rd); end
        xfer(0, 10'h006, 1'b1, 32'h99999999, 4'hF, rd, er, lat);
        model_xfer(0, 10'h004, 1'b0, 32'h0, 4'h0, erd, eer);
        xfer(0, 10'h004, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL err_unal_unchanged: got %h want %h", rd, erd); end
    endtask

    task automatic test_idle_ignore();
        int seen = 0;
        tgt = 0; paddr = 10'h004; pwrite = 1'b0; psel = 1'b0; penable = 1'b1;
        repeat (2) begin @(negedge clk); if (obs_pready) seen++; end
        psel = 1'b1;
        repeat (3) begin @(negedge clk); if (obs_pready) seen++; end
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL idle_ignore: got %0d pready cycles want 0", seen); end
    endtask

    task automatic test_abort();
        logic [31:0] rd, erd; logic er, eer; int lat; int seen = 0;
        model_xfer(1, 10'h010, 1'b1, 32'h0BADF00D, 4'hF, erd, eer);
        xfer(1, 10'h010, 1'b1, 32'h0BADF00D, 4'hF, rd, er, lat);
        tgt = 1; paddr = 10'h010; pwrite = 1'b1; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
        psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk); if (obs_pready) seen++;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (5) begin @(negedge clk); if (obs_pready) seen++; end
        @(posedge clk); #1;
        n_checks++; if (seen != 0) begin n_fail++; $display("FAIL abort_pready: got %0d pready cycles want 0", seen); end
        model_xfer(1, 10'h010, 1'b0, 32'h0, 4'h0, erd, eer);
        xfer(1, 10'h010, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (lat != 4) begin n_fail++; $display("FAIL abort_next_latency: got %0d want 4", lat); end
        n_checks++; if (rd !== 32'h0BADF00D) begin n_fail++; $display("FAIL abort_old_value: got %h want 0badf00d", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, d; logic er, eer, w; logic [9:0] a; logic [3:0] s; int lat, t;
        for (int i = 0; i < 60; i++) begin
            t = int'($urandom_range(0, 1));
            a = 10'($urandom_range(0, 76) * 4);
            if ($urandom_range(0, 4) == 0) a = a | 10'($urandom_range(1, 3));
            w = 1'($urandom_range(0, 1));
            d = $urandom;
            s = 4'($urandom);
            model_xfer(t, a, w, d, s, erd, eer);
            xfer(t, a, w, d, s, rd, er, lat);
            n_checks++; if (lat != wc[t] + 1) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, wc[t] + 1); end
            n_checks++; if (er !== eer) begin n_fail++; $display("FAIL rand_pslverr[%0d] a=%h: got %b want %b", i, a, er, eer); end
            n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL rand_prdata[%0d] a=%h: got %h want %h", i, a, rd, erd); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat;
        tgt = 0; paddr = 10'h014; pwrite = 1'b1; pwdata = 32'h12345678; pstrb = 4'hF;
        psel = 1'b1; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        n_checks++; if (obs_pready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ack: got %b want 1", obs_pready); end
        rst_n = 1'b0;
        #1;
        n_checks++; if ({bus0.pready, bus0.pslverr, bus0.prdata} !== 34'h0) begin n_fail++; $display("FAIL rstmid_outputs0: got %b%b/%h want 0", bus0.pready, bus0.pslverr, bus0.prdata); end
        psel = 1'b0; penable = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(0, 10'h014, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (lat != 1) begin n_fail++; $display("FAIL rstmid_first_setup: got %0d want 1", lat); end
        n_checks++; if (rd !== mem_m[0][5]) begin n_fail++; $display("FAIL rstmid_no_write: got %h want %h", rd, mem_m[0][5]); end
        xfer(0, 10'h004, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (rd !== mem_m[0][1]) begin n_fail++; $display("FAIL rstmid_cleared0: got %h want %h", rd, mem_m[0][1]); end
        xfer(1, 10'h010, 1'b0, 32'h0, 4'h0, rd, er, lat);
        n_checks++; if (rd !== mem_m[1][4]) begin n_fail++; $display("FAIL rstmid_cleared3: got %h want %h", rd, mem_m[1][4]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, erd; logic er, eer; int lat; time t0, t1;
        for (int t = 0; t < 2; t++) begin
            model_xfer(t, 10'h030, 1'b1, 32'h600D0000 + 32'(t), 4'hF, erd, eer);
            xfer(t, 10'h030, 1'b1, 32'h600D0000 + 32'(t), 4'hF, rd, er, lat);
            for (int k = 0; k < 2; k++) begin
                t0 = $time;
                model_xfer(t, 10'h030, 1'b0, 32'h0, 4'h0, erd, eer);
                xfer(t, 10'h030, 1'b0, 32'h0, 4'h0, rd, er, lat);
                t1 = $time;
                n_checks++; if ((t1 - t0) / 10 != time'(2 + wc[t])) begin n_fail++; $display("FAIL b2b_cycles[%0d.%0d]: got %0d want %0d", t, k, (t1 - t0) / 10, 2 + wc[t]); end
                n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL b2b_data[%0d.%0d]: got %h want %h", t, k, rd, erd); end
            end
        end
    endtask

    task automatic test_idle_outputs();
        n_checks++; if (idle_leak != 0) begin n_fail++; $display("FAIL prdata_outside_ack: got %0d nonzero cycles want 0", idle_leak); end
    endtask

    initial begin
        wc[0] = 0;
        wc[1] = 3;
        test_reset();
        test_write_read();
        test_strobes();
        test_wait_states();
        test_errors();
        test_idle_ignore();
        test_abort();
        test_random();
        test_reset_mid();
        test_back_to_back();
        test_idle_outputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
